// File: rtl/spi_xfer_pkg.sv
// Shared state encoding and default timing for the SPI burst controller.
package spi_xfer_pkg;

  localparam int MAX_LEN_DEF  = 16;
  localparam int CS_SETUP_DEF = 4;
  localparam int CS_HOLD_DEF  = 4;
  localparam int CS_GAP_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE, SETUP, REQ, WAIT_ACK, GAP1, HOLD, DESEL, DONE
  } xfer_state_e;

endpackage

// File: rtl/spi_byte_ram.sv
// Small register-file buffer: synchronous write, asynchronous read, no reset.
module spi_byte_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Burst sequencer for an external SPI byte engine: frames CS, issues one
// byte request at a time from a TX buffer and captures replies into an RX buffer.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF,
  parameter int CS_GAP   = CS_GAP_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [4:0]  len,
  input  logic [15:0] clk_div_cfg,
  input  logic        tx_we,
  input  logic [3:0]  tx_addr,
  input  logic [7:0]  tx_wdata,
  input  logic [3:0]  rx_addr,
  output logic [7:0]  rx_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cs_ctrl,
  output logic [15:0] clk_div_val,
  output logic        wr_req,
  output logic [7:0]  data_tx,
  input  logic        wr_ack,
  input  logic [7:0]  data_rx
);

  localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

  xfer_state_e state, state_nxt;
  logic [15:0] cnt;
  logic [3:0]  byte_idx;
  logic [4:0]  len_q;
  logic [7:0]  tx_rd;
  logic        len_ok, last_byte, ack_hit;

  assign len_ok    = (len != 5'd0) && (len <= MAX_LEN_W);
  assign ack_hit   = (state == WAIT_ACK) && wr_ack;
  assign last_byte = ({1'b0, byte_idx} == (len_q - 5'd1));

  assign busy   = (state != IDLE);
  assign wr_req = (state == REQ);
  assign done   = (state == DONE);

  // Counter holds (cycles remaining - 1) of the timed phase being entered.
  function automatic logic [15:0] phase_len(xfer_state_e s);
    case (s)
      SETUP:   phase_len = 16'(CS_SETUP - 1);
      HOLD:    phase_len = 16'(CS_HOLD - 1);
      DESEL:   phase_len = 16'(CS_GAP - 1);
      default: phase_len = 16'd0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && len_ok) state_nxt = SETUP;
      SETUP:    if (cnt == 16'd0) state_nxt = REQ;
      REQ:      state_nxt = WAIT_ACK;
      WAIT_ACK: if (wr_ack) state_nxt = last_byte ? HOLD : GAP1;
      GAP1:     state_nxt = REQ;
      HOLD:     if (cnt == 16'd0) state_nxt = DESEL;
      DESEL:    if (cnt == 16'd0) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      byte_idx    <= 4'd0;
      len_q       <= 5'd0;
      clk_div_val <= 16'd0;
      cs_ctrl     <= 1'b1;
      err         <= 1'b0;
      data_tx     <= 8'd0;
    end else begin
      state <= state_nxt;
      err   <= (state == IDLE) && start && !len_ok;

      if (state_nxt != state)   cnt <= phase_len(state_nxt);
      else if (cnt != 16'd0)    cnt <= cnt - 16'd1;

      if (state == IDLE && state_nxt == SETUP) begin
        len_q       <= len;
        clk_div_val <= clk_div_cfg;
        byte_idx    <= 4'd0;
        cs_ctrl     <= 1'b0;
      end

      if (ack_hit && !last_byte) byte_idx <= byte_idx + 4'd1;
      if (state == HOLD && state_nxt == DESEL) cs_ctrl <= 1'b1;

      // TX buffer is frozen while busy, so the byte loaded here stays valid until its ack.
      if (state_nxt == REQ && state != REQ) data_tx <= tx_rd;
    end
  end

  spi_byte_ram #(.DEPTH(16), .WIDTH(8)) u_tx_ram (
    .clk   (sys_clk),
    .we    (tx_we && !busy),
    .waddr (tx_addr),
    .wdata (tx_wdata),
    .raddr (byte_idx),
    .rdata (tx_rd)
  );

  spi_byte_ram #(.DEPTH(16), .WIDTH(8)) u_rx_ram (
    .clk   (sys_clk),
    .we    (ack_hit),
    .waddr (byte_idx),
    .wdata (data_rx),
    .raddr (rx_addr),
    .rdata (rx_rdata)
  );

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a loopback byte-engine model.
module tb_spi_xfer_ctrl;

  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 8;
  localparam int K_REQ = 0, K_DONE = 1, K_ERR = 2;

  typedef struct { int kind; int data; } exp_t;

  logic        sys_clk, sys_rst, start, tx_we, wr_ack, busy, done, err, cs_ctrl, wr_req;
  logic [4:0]  len;
  logic [15:0] clk_div_cfg, clk_div_val;
  logic [3:0]  tx_addr, rx_addr;
  logic [7:0]  tx_wdata, rx_rdata, data_tx, data_rx;
  logic        eng_ack, stray_ack;
  logic [7:0]  eng_data;

  exp_t       exp_q[$];
  logic [7:0] tx_model [16];
  int         n_pass, n_chk, cyc, ack_dly;

  assign wr_ack  = eng_ack | stray_ack;
  assign data_rx = stray_ack ? 8'hEE : eng_data;

  spi_xfer_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .len(len),
    .clk_div_cfg(clk_div_cfg), .tx_we(tx_we), .tx_addr(tx_addr), .tx_wdata(tx_wdata),
    .rx_addr(rx_addr), .rx_rdata(rx_rdata), .busy(busy), .done(done), .err(err),
    .cs_ctrl(cs_ctrl), .clk_div_val(clk_div_val), .wr_req(wr_req), .data_tx(data_tx),
    .wr_ack(wr_ack), .data_rx(data_rx)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge sys_clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic mon_pop(input int kind, input int data, input string name);
    exp_t e;
    check("event_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_data"}, data, e.data);
    end
  endtask

  // Byte engine model: loops MOSI back to MISO, acks ack_dly cycles after a request.
  initial begin
    logic [7:0] d;
    eng_ack = 1'b0;
    eng_data = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (wr_req && !sys_rst) begin
        d = data_tx;
        repeat (ack_dly) @(posedge sys_clk);
        #1 eng_ack = 1'b1; eng_data = d;
        @(posedge sys_clk);
        #1 eng_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every wr_req / done / err and checks CS timing.
  initial begin
    int req_n, lo_n, hi_n, last_ack;
    req_n = 0; lo_n = 0; hi_n = 0; last_ack = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        req_n = 0;
      end else begin
        if (wr_ack) last_ack = cyc;
        if (cs_ctrl) begin hi_n++; lo_n = 0; end
        else begin lo_n++; hi_n = 0; end
        if (wr_req) begin
          if (req_n == 0) check("cs_setup_cycles", lo_n - 1, CS_SETUP);
          else            check("req_after_ack", cyc - last_ack, 2);
          req_n++;
          mon_pop(K_REQ, int'(data_tx), "tx_byte");
        end
        if (done) begin
          check("ack_to_done", cyc - last_ack, CS_HOLD + CS_GAP + 1);
          check("cs_gap_cycles", hi_n - 1, CS_GAP);
          mon_pop(K_DONE, req_n, "burst_bytes");
          req_n = 0;
        end
        if (err) mon_pop(K_ERR, 0, "err_pulse");
      end
    end
  end

  task automatic tx_write(input int a, input logic [7:0] d);
    @(posedge sys_clk); #1;
    tx_we = 1'b1; tx_addr = 4'(a); tx_wdata = d;
    tx_model[a] = d;
    @(posedge sys_clk); #1;
    tx_we = 1'b0;
  endtask

  task automatic start_burst(input int l, input logic [15:0] cfg);
    @(posedge sys_clk); #1;
    start = 1'b1; len = 5'(l); clk_div_cfg = cfg;
    if (l >= 1 && l <= 16) begin
      for (int i = 0; i < l; i++) exp_q.push_back('{K_REQ, int'(tx_model[i])});
      exp_q.push_back('{K_DONE, l});
    end else begin
      exp_q.push_back('{K_ERR, 0});
    end
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge sys_clk);
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1);
  endtask

  task automatic wait_reqs(input int n, input int maxc);
    int seen;
    seen = 0;
    for (int i = 0; i < maxc && seen < n; i++) begin
      @(negedge sys_clk);
      if (wr_req) seen++;
    end
    check("reqs_seen", seen, n);
  endtask

  task automatic rx_check(input int a, input logic [7:0] exp);
    rx_addr = 4'(a);
    #1 check($sformatf("rx_buf[%0d]", a), rx_rdata, exp);
  endtask

  task automatic idle_watch(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (busy || !cs_ctrl) bad++;
    end
    check("idle_quiet", bad, 0);
  endtask

  initial begin
    n_pass = 0; n_chk = 0; ack_dly = 1;
    start = 1'b0; len = 5'd0; clk_div_cfg = 16'd0; tx_we = 1'b0;
    tx_addr = 4'd0; tx_wdata = 8'd0; rx_addr = 4'd0; stray_ack = 1'b0;
    for (int i = 0; i < 16; i++) tx_model[i] = 8'h00;
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_cs_ctrl", cs_ctrl, 1);
    check("rst_wr_req", wr_req, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_data_tx", data_tx, 0);
    check("rst_clk_div_val", clk_div_val, 0);
    sys_rst = 1'b0;

    // Single byte loopback
    tx_write(0, 8'hA5);
    start_burst(1, 16'h0004);
    wait_done(100);
    rx_check(0, 8'hA5);
    check("clk_div_latched", clk_div_val, 16'h0004);

    // Full 16-byte burst; divider input changes mid-burst must not leak through
    for (int i = 0; i < 16; i++) tx_write(i, 8'(i * 8'h11));
    start_burst(16, 16'h0010);
    clk_div_cfg = 16'hBEEF;
    repeat (20) @(posedge sys_clk);
    #1 check("clk_div_stable", clk_div_val, 16'h0010);
    wait_done(300);
    for (int i = 0; i < 16; i++) rx_check(i, 8'(i * 8'h11));

    // Illegal lengths
    start_burst(0, 16'h0001);
    idle_watch(6);
    start_burst(17, 16'h0001);
    idle_watch(6);

    // Busy protection: start + TX write at byte 3 of an 8-byte burst
    for (int i = 0; i < 8; i++) tx_write(i, 8'hC0 + 8'(i));
    start_burst(8, 16'h0002);
    wait_reqs(4, 100);
    @(posedge sys_clk); #1;
    start = 1'b1; len = 5'd3; tx_we = 1'b1; tx_addr = 4'd5; tx_wdata = 8'hFF;
    rx_addr = 4'd7;
    #1 check("rx_prev_during_burst", rx_rdata, 8'h77);
    @(posedge sys_clk); #1;
    start = 1'b0; tx_we = 1'b0;
    wait_done(200);
    for (int i = 0; i < 8; i++) rx_check(i, 8'hC0 + 8'(i));

    // Reset in WAIT_ACK of byte 2, then a fresh 2-byte burst
    ack_dly = 3;
    start_burst(4, 16'h0003);
    wait_reqs(3, 100);
    @(posedge sys_clk); #2;
    sys_rst = 1'b1;
    #1;
    check("midrst_cs_ctrl", cs_ctrl, 1);
    check("midrst_wr_req", wr_req, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    ack_dly = 1;
    repeat (10) @(posedge sys_clk);
    tx_write(0, 8'h12);
    tx_write(1, 8'h34);
    start_burst(2, 16'h0005);
    wait_done(100);
    rx_check(0, 8'h12);
    rx_check(1, 8'h34);

    // Stray ack during SETUP
    tx_write(0, 8'h3C);
    start_burst(1, 16'h0006);
    stray_ack = 1'b1;
    @(posedge sys_clk); #1;
    stray_ack = 1'b0;
    wait_done(100);
    rx_check(0, 8'h3C);

    repeat (4) @(posedge sys_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
